input_debouncer: RTL and testbench

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

---
 rtl/input_debouncer_pkg.sv | 14 +
 rtl/input_debouncer_channel.sv | 52 +++++
 rtl/input_debouncer.sv | 45 ++++
 tb/tb_input_debouncer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/input_debouncer_pkg.sv
// Shared project constants for the input debouncer: board channel count and
// default filter timing.
package input_debouncer_pkg;

  localparam int BOARD_CHANNELS        = 4;
  localparam int STABLE_CYCLES_DEFAULT = 16;
  localparam int SYNC_STAGES_DEFAULT   = 2;

  // Counter must hold 0..stable_cycles-1; guards the degenerate width-0 case.
  function automatic int counter_width(input int stable_cycles);
    return (stable_cycles < 2) ? 1 : $clog2(stable_cycles);
  endfunction

endpackage

// File: rtl/input_debouncer_channel.sv
// One debounce channel: synchronizer chain, stability counter, clean level
// register and registered rise/fall pulses.
module debounce_channel
  import input_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam int            CW       = counter_width(STABLE_CYCLES);
  localparam logic [CW-1:0] TERMINAL = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync;
  logic [CW-1:0]          count;

  assign sync = sync_chain[SYNC_STAGES-1];

  // Terminal count reached while still disagreeing: this edge commits the change.
  assign accept = (sync != clean) && (count == TERMINAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_chain <= '0;
      count      <= '0;
      clean      <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};
      rise       <= accept & sync;
      fall       <= accept & ~sync;
      if (sync == clean) begin
        count <= '0;
      end else if (accept) begin
        count <= '0;
        clean <= sync;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel switch/button debouncer; each channel is independent and the
// only shared logic is the registered any-change flag.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int CHANNELS      = BOARD_CHANNELS,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEFAULT
) (
  input  logic                i_Clock,
  input  logic                i_Reset,
  input  logic [CHANNELS-1:0] i_Raw,
  output logic [CHANNELS-1:0] o_Clean,
  output logic [CHANNELS-1:0] o_Rise,
  output logic [CHANNELS-1:0] o_Fall,
  output logic                o_Changed
);

  logic [CHANNELS-1:0] accept;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_channel
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES)
    ) u_channel (
      .clk   (i_Clock),
      .rst   (i_Reset),
      .raw   (i_Raw[n]),
      .clean (o_Clean[n]),
      .rise  (o_Rise[n]),
      .fall  (o_Fall[n]),
      .accept(accept[n])
    );
  end

  // Registered from the same accept terms as the pulses so it lines up with them.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Changed <= 1'b0;
    end else begin
      o_Changed <= |accept;
    end
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: a fast instance (STABLE_CYCLES=4) for
// functional cases and a default instance for the 18-edge latency.
module tb_input_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] raw;
  logic [3:0] clean, rise, fall;
  logic       changed;

  logic       rst_def;
  logic [3:0] raw_def;
  logic [3:0] clean_def, rise_def, fall_def;
  logic       changed_def;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  input_debouncer #(.CHANNELS(4), .STABLE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .i_Clock  (clk),
    .i_Reset  (rst),
    .i_Raw    (raw),
    .o_Clean  (clean),
    .o_Rise   (rise),
    .o_Fall   (fall),
    .o_Changed(changed)
  );

  input_debouncer dut_def (
    .i_Clock  (clk),
    .i_Reset  (rst_def),
    .i_Raw    (raw_def),
    .o_Clean  (clean_def),
    .o_Rise   (rise_def),
    .o_Fall   (fall_def),
    .o_Changed(changed_def)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] c, input logic [3:0] r,
                           input logic [3:0] f, input logic ch);
    check({tag, ".clean"}, 32'(clean), 32'(c));
    check({tag, ".rise"}, 32'(rise), 32'(r));
    check({tag, ".fall"}, 32'(fall), 32'(f));
    check({tag, ".changed"}, 32'(changed), 32'(ch));
  endtask

  initial begin
    rst     = 1'b1;
    raw     = 4'b0000;
    rst_def = 1'b1;
    raw_def = 4'b0000;
    step(2);
    check_all("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Single channel rise, 6-edge latency
    rst = 1'b0;
    raw = 4'b0001;
    step(5);
    check_all("rise0_pre", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(1);
    check_all("rise0_edge", 4'b0001, 4'b0001, 4'b0000, 1'b1);
    step(1);
    check_all("rise0_after", 4'b0001, 4'b0000, 4'b0000, 1'b0);

    // 3-cycle glitch is rejected
    raw = 4'b0000;
    step(3);
    raw = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check_all("glitch", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    end

    // Simultaneous rise on two channels from a clean zero state
    rst = 1'b1;
    step(1);
    check_all("reset2", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;
    raw = 4'b1010;
    step(5);
    check_all("multi_pre", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(1);
    check_all("multi_edge", 4'b1010, 4'b1010, 4'b0000, 1'b1);
    step(1);
    check_all("multi_after", 4'b1010, 4'b0000, 4'b0000, 1'b0);

    // Reset mid-count discards progress
    rst = 1'b1;
    raw = 4'b0000;
    step(1);
    rst = 1'b0;
    raw = 4'b0100;
    step(3);
    rst = 1'b1;
    step(1);
    check_all("midreset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;
    step(5);
    check_all("midreset_pre", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(1);
    check_all("midreset_edge", 4'b0100, 4'b0100, 4'b0000, 1'b1);

    // All high, then all fall together
    raw = 4'b1111;
    step(6);
    check_all("allhigh_edge", 4'b1111, 4'b1011, 4'b0000, 1'b1);
    step(1);
    raw = 4'b0000;
    step(5);
    check_all("fall_pre", 4'b1111, 4'b0000, 4'b0000, 1'b0);
    step(1);
    check_all("fall_edge", 4'b0000, 4'b0000, 4'b1111, 1'b1);
    step(1);
    check_all("fall_after", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Default parameters: 2 + 16 = 18 edges
    rst_def = 1'b0;
    raw_def = 4'b0001;
    step(17);
    check("def_pre.clean", 32'(clean_def), 32'(4'b0000));
    check("def_pre.changed", 32'(changed_def), 32'(1'b0));
    step(1);
    check("def_edge.clean", 32'(clean_def), 32'(4'b0001));
    check("def_edge.rise", 32'(rise_def), 32'(4'b0001));
    check("def_edge.fall", 32'(fall_def), 32'(4'b0000));
    check("def_edge.changed", 32'(changed_def), 32'(1'b1));
    step(1);
    check("def_after.rise", 32'(rise_def), 32'(4'b0000));

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
